// File: rtl/vmmul_result_writer_if.sv
// Addressed word stream with a valid/ready handshake.
// Carries both the core result stream and the memory write bus.
interface vmmul_result_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;

  modport master (
    output valid,
    output data,
    output addr,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  addr,
    output ready
  );

endinterface

// File: rtl/vmmul_result_writer.sv
// VMMUL result writeback: buffers result words and writes one tile
// to data memory, checking every address against the armed window.
module vmmul_result_writer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_base_addr,
  vmmul_result_writer_if.slave  i_res,
  vmmul_result_writer_if.master o_mem,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [4:0]            o_words_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [4:0] TILE_N =
    5'(TILE_WORDS);
  localparam logic [LVL_W-1:0] FULL_N =
    LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] SPAN =
    (ADDR_W+1)'(4 * (TILE_WORDS - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [4:0]        r_acc;
  logic [4:0]        r_wr;
  logic              r_err;
  logic              r_done;
  logic              r_busy;

  logic [LVL_W-1:0]  r_level;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [DATA_W-1:0] r_fifo_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_a [FIFO_DEPTH];

  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [ADDR_W:0]   w_hi_ext;
  logic [ADDR_W-1:0] w_hi;
  logic              w_wrap;
  logic              w_legal;
  logic              w_ready;
  logic              w_hs;
  logic              w_push;
  logic              w_bad;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rptr_n;
  logic [LVL_W-1:0]  w_level_n;
  logic [4:0]        w_acc_n;
  logic [4:0]        w_wr_n;
  logic              w_bypass;
  logic [ADDR_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_d;

  // A window whose top wraps past 2^ADDR_W rejects every word.
  assign w_hi_ext = {1'b0, r_base} + SPAN;
  assign w_wrap   = w_hi_ext[ADDR_W];
  assign w_hi     = w_hi_ext[ADDR_W-1:0];

  assign w_legal = (i_res.addr[1:0] == 2'b00)
                && !w_wrap
                && (i_res.addr >= r_base)
                && (i_res.addr <= w_hi);

  assign w_ready = (r_state == S_COLLECT)
                && (r_level != FULL_N)
                && (r_acc < TILE_N);

  assign i_res.ready = w_ready;

  assign w_hs   = i_res.valid && w_ready;
  assign w_push = w_hs && w_legal;
  assign w_bad  = w_hs && !w_legal;
  assign w_pop  = r_req && o_mem.ready;

  assign w_rptr_n = w_pop ? r_rptr + PTR_W'(1)
                          : r_rptr;

  assign w_level_n = r_level
                   + LVL_W'(w_push)
                   - LVL_W'(w_pop);

  assign w_acc_n = r_acc + 5'(w_push);
  assign w_wr_n  = r_wr + 5'(w_pop);

  // A word pushed into an empty (or emptying) FIFO becomes the head.
  assign w_bypass = w_push && (r_wptr == w_rptr_n);

  assign w_head_a = w_bypass ? i_res.addr
                             : r_fifo_a[w_rptr_n];
  assign w_head_d = w_bypass ? i_res.data
                             : r_fifo_d[w_rptr_n];

  assign o_mem.valid     = r_req;
  assign o_mem.addr      = r_addr;
  assign o_mem.data      = r_wdata;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_words_written = r_wr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_d[r_wptr] <= i_res.data;
      r_fifo_a[r_wptr] <= i_res.addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_level <= w_level_n;
      r_rptr  <= w_rptr_n;
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      r_req <= (w_level_n != '0);
      if (w_level_n != '0) begin
        r_addr  <= w_head_a;
        r_wdata <= w_head_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_acc   <= '0;
      r_wr    <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_COLLECT;
            r_base  <= i_base_addr;
            r_acc   <= '0;
            r_wr    <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          r_acc <= w_acc_n;
          r_wr  <= w_wr_n;
          if (w_bad) begin
            r_err <= 1'b1;
          end
          if (w_acc_n == TILE_N) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_wr <= w_wr_n;
          if (w_wr_n == TILE_N) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmmul_result_writer.sv
// Scoreboard bench for vmmul_result_writer: result stream in,
// memory writes out, compared in order against pushed expectations.
module tb_vmmul_result_writer;

  localparam int DW = 32;
  localparam int AW = 32;

  localparam logic [31:0] MAT [16] = '{
    32'd90,  32'd100, 32'd110, 32'd120,
    32'd202, 32'd228, 32'd254, 32'd280,
    32'd314, 32'd356, 32'd398, 32'd440,
    32'd426, 32'd484, 32'd542, 32'd600
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  words;

  vmmul_result_writer_if #(.DATA_W(DW), .ADDR_W(AW)) res_if ();
  vmmul_result_writer_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  vmmul_result_writer #(
    .DATA_W(DW), .ADDR_W(AW),
    .FIFO_DEPTH(4), .TILE_WORDS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .i_base_addr(base),
    .i_res(res_if),
    .o_mem(mem_if),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_words_written(words)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_in_a [$];
  logic [31:0] q_in_d [$];
  bit          q_in_ok [$];
  logic [31:0] q_exp_a [$];
  logic [31:0] q_exp_d [$];
  logic [31:0] q_act_a [$];
  logic [31:0] q_act_d [$];

  bit cur_ok = 1'b0;
  bit p_acc, p_wr, p_bad;
  bit bad_seen = 1'b0;
  int n_acc = 0;
  int n_wr = 0;

  // Handshakes are decided at the next rising edge; sample mid-cycle.
  always @(negedge clk) begin
    p_acc = 1'b0;
    p_wr  = 1'b0;
    p_bad = 1'b0;
    if (!rst && res_if.valid && res_if.ready) begin
      if (cur_ok) begin
        p_acc = 1'b1;
        q_exp_a.push_back(res_if.addr);
        q_exp_d.push_back(res_if.data);
      end else begin
        p_bad = 1'b1;
      end
    end
    if (!rst && mem_if.valid && mem_if.ready) begin
      p_wr = 1'b1;
      q_act_a.push_back(mem_if.addr);
      q_act_d.push_back(mem_if.data);
    end
  end

  always @(posedge clk) begin
    if (p_acc) n_acc++;
    if (p_wr) n_wr++;
    if (p_bad) bad_seen = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic load(input logic [31:0] a,
                      input logic [31:0] d,
                      input bit ok);
    q_in_a.push_back(a);
    q_in_d.push_back(d);
    q_in_ok.push_back(ok);
  endtask

  task automatic feed(output int cycles);
    cycles = 0;
    while (q_in_a.size() > 0 && cycles < 400) begin
      res_if.valid = 1'b1;
      res_if.addr  = q_in_a[0];
      res_if.data  = q_in_d[0];
      cur_ok       = q_in_ok[0];
      @(negedge clk);
      if (res_if.ready) begin
        q_in_a.delete(0);
        q_in_d.delete(0);
        q_in_ok.delete(0);
      end
      @(posedge clk); #1;
      cycles++;
    end
    res_if.valid = 1'b0;
    cur_ok = 1'b0;
    checks++;
    if (q_in_a.size() != 0) begin
      errors++;
      $display("FAIL feed_timeout left=%0d exp=0", q_in_a.size());
      q_in_a.delete();
      q_in_d.delete();
      q_in_ok.delete();
    end
  endtask

  task automatic start_tile(input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    @(posedge clk); #1;
    start = 1'b0;
    bad_seen = 1'b0;
    n_acc = 0;
    n_wr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    base = 32'h3000;
    res_if.valid = 1'b1;
    res_if.addr = 32'h3000;
    res_if.data = 32'h1234;
    cur_ok = 1'b1;
    mem_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({res_if.ready, mem_if.valid, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
        {res_if.ready, mem_if.valid, busy, done, err});
    end
    checks++;
    if (mem_if.addr !== 32'h0 || mem_if.data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", mem_if.addr, mem_if.data);
    end
    checks++;
    if (words !== 5'd0) begin
      errors++;
      $display("FAIL reset_words got=%0d exp=0", words);
    end
    @(negedge clk);
    checks++;
    if (res_if.ready !== 1'b0 || mem_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got=%b%b exp=00", res_if.ready, mem_if.valid);
    end
    res_if.valid = 1'b0;
    cur_ok = 1'b0;
  endtask

  task automatic test_nominal();
    int cyc;
    logic [31:0] ea, ed, aa, ad;
    mem_if.ready = 1'b1;
    start_tile(32'h3000);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL nom_start got=%b%b exp=10", busy, done);
    end
    for (int i = 0; i < 16; i++)
      load(32'h3000 + 32'(4 * i), MAT[i], 1'b1);
    feed(cyc);
    checks++;
    if (cyc != 16) begin
      errors++;
      $display("FAIL nom_throughput got=%0d exp=16", cyc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || words !== 5'd15) begin
      errors++;
      $display("FAIL nom_pre_done got=%b/%0d exp=0/15", done, words);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, err} !== 3'b100 || words !== 5'd16) begin
      errors++;
      $display("FAIL nom_done got=%b/%0d exp=100/16", {done, busy, err}, words);
    end
    checks++;
    if (q_act_a.size() != 16 || q_exp_a.size() != 16) begin
      errors++;
      $display("FAIL nom_count got=%0d exp=16", q_act_a.size());
    end
    while (q_exp_a.size() > 0 && q_act_a.size() > 0) begin
      ea = q_exp_a.pop_front(); ed = q_exp_d.pop_front();
      aa = q_act_a.pop_front(); ad = q_act_d.pop_front();
      checks++;
      if (aa !== ea || ad !== ed) begin
        errors++;
        $display("FAIL nom_write got=%h:%0d exp=%h:%0d", aa, ad, ea, ed);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL nom_hold got=%b%b exp=10", done, mem_if.valid);
    end
    q_exp_a.delete(); q_exp_d.delete();
    q_act_a.delete(); q_act_d.delete();
  endtask

  task automatic test_backpressure();
    int cyc;
    int c;
    bit stalled;
    bit saw_full;
    logic [31:0] la, ld, ea, ed, aa, ad;
    c = 0;
    stalled = 1'b0;
    saw_full = 1'b0;
    start_tile(32'h3000);
    for (int i = 0; i < 16; i++)
      load(32'h3000 + 32'(4 * i), $urandom, 1'b1);
    mem_if.ready = 1'b0;
    fork
      feed(cyc);
      begin
        while (n_wr < 16 && c < 400) begin
          @(negedge clk);
          if (mem_if.valid && stalled) begin
            checks++;
            if (mem_if.addr !== la || mem_if.data !== ld) begin
              errors++;
              $display("FAIL bp_stable got=%h:%h exp=%h:%h",
                mem_if.addr, mem_if.data, la, ld);
            end
          end
          stalled = mem_if.valid && !mem_if.ready;
          la = mem_if.addr;
          ld = mem_if.data;
          if (busy && !res_if.ready && n_acc < 16) begin
            saw_full = 1'b1;
            checks++;
            if (n_acc - n_wr != 4) begin
              errors++;
              $display("FAIL bp_level got=%0d exp=4", n_acc - n_wr);
            end
          end
          @(posedge clk); #1;
          c++;
          mem_if.ready = (c % 4 == 3);
        end
      end
    join
    mem_if.ready = 1'b1;
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL bp_in_ready_drop got=0 exp=1");
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || words !== 5'd16 || err !== 1'b0) begin
      errors++;
      $display("FAIL bp_done got=%b/%0d/%b exp=1/16/0", done, words, err);
    end
    checks++;
    if (q_act_a.size() != 16 || q_exp_a.size() != 16) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=16", q_act_a.size());
    end
    while (q_exp_a.size() > 0 && q_act_a.size() > 0) begin
      ea = q_exp_a.pop_front(); ed = q_exp_d.pop_front();
      aa = q_act_a.pop_front(); ad = q_act_d.pop_front();
      checks++;
      if (aa !== ea || ad !== ed) begin
        errors++;
        $display("FAIL bp_write got=%h:%h exp=%h:%h", aa, ad, ea, ed);
      end
    end
    q_exp_a.delete(); q_exp_d.delete();
    q_act_a.delete(); q_act_d.delete();
  endtask

  task automatic test_bad_addr();
    int cyc;
    int c;
    bit feeding;
    logic [31:0] ea, ed, aa, ad;
    mem_if.ready = 1'b1;
    start_tile(32'h3000);
    for (int i = 0; i < 4; i++)
      load(32'h3000 + 32'(4 * i), $urandom, 1'b1);
    load(32'h3002, 32'hBAD0, 1'b0);
    load(32'h30F0, 32'hBAD1, 1'b0);
    load(32'h2FFC, 32'hBAD2, 1'b0);
    load(32'h3040, 32'hBAD3, 1'b0);
    for (int i = 4; i < 16; i++)
      load(32'h3000 + 32'(4 * i), $urandom, 1'b1);
    feeding = 1'b1;
    fork
      begin
        feed(cyc);
        feeding = 1'b0;
      end
      while (feeding) begin
        @(negedge clk);
        checks++;
        if (err !== bad_seen) begin
          errors++;
          $display("FAIL bad_err_timing got=%b exp=%b", err, bad_seen);
        end
      end
    join
    c = 0;
    while (done !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || words !== 5'd16) begin
      errors++;
      $display("FAIL bad_done got=%b/%b/%0d exp=1/1/16", done, err, words);
    end
    checks++;
    if (q_act_a.size() != 16 || q_exp_a.size() != 16) begin
      errors++;
      $display("FAIL bad_count got=%0d exp=16", q_act_a.size());
    end
    while (q_exp_a.size() > 0 && q_act_a.size() > 0) begin
      ea = q_exp_a.pop_front(); ed = q_exp_d.pop_front();
      aa = q_act_a.pop_front(); ad = q_act_d.pop_front();
      checks++;
      if (aa !== ea || ad !== ed) begin
        errors++;
        $display("FAIL bad_write got=%h:%h exp=%h:%h", aa, ad, ea, ed);
      end
    end
    q_exp_a.delete(); q_exp_d.delete();
    q_act_a.delete(); q_act_d.delete();
  endtask

  task automatic test_start_busy();
    int cyc;
    int c;
    logic [31:0] ea, ed, aa, ad;
    c = 0;
    mem_if.ready = 1'b1;
    start_tile(32'h3000);
    for (int i = 0; i < 16; i++)
      load(32'h3000 + 32'(4 * i), $urandom, 1'b1);
    fork
      feed(cyc);
      begin
        while (n_wr < 8 && c < 100) begin
          @(posedge clk); #1;
          c++;
        end
        start = 1'b1;
        base = 32'h4000;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL sb_ignored got=%b%b exp=10", busy, done);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || words !== 5'd15) begin
      errors++;
      $display("FAIL sb_pre_done got=%b/%0d exp=0/15", done, words);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b10 || words !== 5'd16) begin
      errors++;
      $display("FAIL sb_done got=%b/%0d exp=10/16", {done, busy}, words);
    end
    checks++;
    if (q_act_a.size() != 16 || q_exp_a.size() != 16) begin
      errors++;
      $display("FAIL sb_count got=%0d exp=16", q_act_a.size());
    end
    while (q_exp_a.size() > 0 && q_act_a.size() > 0) begin
      ea = q_exp_a.pop_front(); ed = q_exp_d.pop_front();
      aa = q_act_a.pop_front(); ad = q_act_d.pop_front();
      checks++;
      if (aa !== ea || ad !== ed) begin
        errors++;
        $display("FAIL sb_write got=%h:%h exp=%h:%h", aa, ad, ea, ed);
      end
    end
    q_exp_a.delete(); q_exp_d.delete();
    q_act_a.delete(); q_act_d.delete();
  endtask

  task automatic test_wrap();
    int cyc;
    mem_if.ready = 1'b1;
    start_tile(32'hFFFF_FFF0);
    load(32'hFFFF_FFF0, 32'h5A5A, 1'b0);
    load(32'hFFFF_FFFC, 32'h5A5B, 1'b0);
    feed(cyc);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || mem_if.valid !== 1'b0 || words !== 5'd0) begin
      errors++;
      $display("FAIL wrap_reject got=%b%b/%0d exp=10/0", err, mem_if.valid, words);
    end
    checks++;
    if (res_if.ready !== 1'b1 || q_act_a.size() != 0) begin
      errors++;
      $display("FAIL wrap_state got=%b/%0d exp=1/0", res_if.ready, q_act_a.size());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_exp_a.delete(); q_exp_d.delete();
    q_act_a.delete(); q_act_d.delete();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int c;
    logic [31:0] ea, ed, aa, ad;
    c = 0;
    mem_if.ready = 1'b1;
    start_tile(32'h3000);
    for (int i = 0; i < 11; i++)
      load(32'h3000 + 32'(4 * i), $urandom, 1'b1);
    fork
      feed(cyc);
      begin
        while (n_wr < 8 && c < 100) begin
          @(posedge clk); #1;
          c++;
        end
        mem_if.ready = 1'b0;
      end
    join
    @(negedge clk);
    checks++;
    if (n_acc - n_wr != 3 || mem_if.valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_queued got=%0d/%b exp=3/1", n_acc - n_wr, mem_if.valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_if.ready = 1'b1;
    checks++;
    if (q_act_a.size() != 8 || q_exp_a.size() != 11) begin
      errors++;
      $display("FAIL rm_count got=%0d exp=8", q_act_a.size());
    end
    while (q_exp_a.size() > 0 && q_act_a.size() > 0) begin
      ea = q_exp_a.pop_front(); ed = q_exp_d.pop_front();
      aa = q_act_a.pop_front(); ad = q_act_d.pop_front();
      checks++;
      if (aa !== ea || ad !== ed) begin
        errors++;
        $display("FAIL rm_write got=%h:%h exp=%h:%h", aa, ad, ea, ed);
      end
    end
    q_exp_a.delete(); q_exp_d.delete();
    @(negedge clk);
    checks++;
    if ({res_if.ready, mem_if.valid, busy, done, err} !== 5'b0 ||
        words !== 5'd0 || mem_if.addr !== 32'h0 || mem_if.data !== 32'h0) begin
      errors++;
      $display("FAIL rm_reset_outs got=%b/%0d/%h exp=00000/0/0",
        {res_if.ready, mem_if.valid, busy, done, err}, words, mem_if.addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_act_a.size() != 0) begin
      errors++;
      $display("FAIL rm_no_writes got=%0d exp=0", q_act_a.size());
    end
    start_tile(32'h3000);
    for (int i = 0; i < 16; i++)
      load(32'h3000 + 32'(4 * i), $urandom, 1'b1);
    feed(cyc);
    c = 0;
    while (done !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (done !== 1'b1 || words !== 5'd16 || err !== 1'b0) begin
      errors++;
      $display("FAIL rm_fresh_done got=%b/%0d/%b exp=1/16/0", done, words, err);
    end
    checks++;
    if (q_act_a.size() != 16 || q_exp_a.size() != 16) begin
      errors++;
      $display("FAIL rm_fresh_count got=%0d exp=16", q_act_a.size());
    end
    while (q_exp_a.size() > 0 && q_act_a.size() > 0) begin
      ea = q_exp_a.pop_front(); ed = q_exp_d.pop_front();
      aa = q_act_a.pop_front(); ad = q_act_d.pop_front();
      checks++;
      if (aa !== ea || ad !== ed) begin
        errors++;
        $display("FAIL rm_fresh_write got=%h:%h exp=%h:%h", aa, ad, ea, ed);
      end
    end
    q_exp_a.delete(); q_exp_d.delete();
    q_act_a.delete(); q_act_d.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_bad_addr();
    test_start_busy();
    test_wrap();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
